// File: rtl/cache_miss_controller.sv
// Sequencing controller for a 4-block fully associative write-back cache.
// Holds the tag/valid/dirty/LRU directory and resolves hits locally. On a miss
// it writes back a dirty victim, then refills the victim block from memory.
module cache_miss_controller #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 5,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic [1:0]        da_way,
    output logic              da_we,
    output logic [DATA_W-1:0] da_wdata,
    input  logic [DATA_W-1:0] da_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWb,
        StFill,
        StResp
    } state_t;

    // Index of the final FILL cycle; memory data is valid in that cycle.
    localparam logic [1:0] FillLast = 2'(MEM_LAT);

    state_t              r_state;
    state_t              w_state_next;

    // Latched request
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    // Directory
    logic [3:0]          r_valid;
    logic [3:0]          r_dirty;
    logic [ADDR_W-1:0]   r_tag [4];
    logic [1:0]          r_age [4];
    logic [1:0]          r_victim;

    logic [1:0]          r_fill_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_hit;
    logic [7:0]          r_hit_cnt;
    logic [7:0]          r_miss_cnt;

    logic                w_hit;
    logic [1:0]          w_hit_way;
    logic [1:0]          w_victim;
    logic                w_fill_last;
    logic                w_acc_en;
    logic [1:0]          w_acc_way;
    logic [1:0]          w_age_next [4];

    assign w_fill_last = (r_fill_cnt == FillLast);

    assign resp_valid  = (r_state == StResp);
    assign resp_rdata  = r_rdata;
    assign resp_hit    = r_hit;
    assign hit_count   = r_hit_cnt;
    assign miss_count  = r_miss_cnt;

    // Tag compare against all valid ways; at most one can match.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_valid[i] && (r_tag[i] == r_addr)) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(i);
            end
        end
    end

    // Victim choice: lowest-index invalid way, otherwise the oldest (age 3) way.
    always_comb begin
        w_victim = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_age[i] == 2'd3) begin
                w_victim = 2'(i);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_victim = 2'(i);
            end
        end
    end

    // LRU ages: touched way becomes 0, every younger way ages by one.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_age_next[i] = r_age[i];
            if (w_acc_en) begin
                if (2'(i) == w_acc_way) begin
                    w_age_next[i] = 2'd0;
                end else if (r_age[i] < r_age[w_acc_way]) begin
                    w_age_next[i] = r_age[i] + 2'd1;
                end
            end
        end
    end

    // Next-state and datapath control outputs.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        da_way       = 2'd0;
        da_we        = 1'b0;
        da_wdata     = '0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        w_acc_en     = 1'b0;
        w_acc_way    = 2'd0;

        case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = StLookup;
                end
            end

            StLookup: begin
                if (w_hit) begin
                    da_way    = w_hit_way;
                    w_acc_en  = 1'b1;
                    w_acc_way = w_hit_way;
                    if (r_write) begin
                        da_we    = 1'b1;
                        da_wdata = r_wdata;
                    end
                    w_state_next = StResp;
                end else if (r_valid[w_victim] && r_dirty[w_victim]) begin
                    w_state_next = StWb;
                end else begin
                    w_state_next = StFill;
                end
            end

            StWb: begin
                da_way       = r_victim;
                mem_we       = 1'b1;
                mem_addr     = r_tag[r_victim];
                mem_wdata    = da_rdata;
                w_state_next = StFill;
            end

            StFill: begin
                mem_addr = r_addr;
                if (w_fill_last) begin
                    da_way       = r_victim;
                    da_we        = 1'b1;
                    da_wdata     = r_write ? r_wdata : mem_rdata;
                    w_acc_en     = 1'b1;
                    w_acc_way    = r_victim;
                    w_state_next = StResp;
                end
            end

            StResp: begin
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the request on acceptance in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == StIdle) && req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Directory: LRU ages, dirty-on-write-hit, and block install at end of fill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 4'b0;
            r_dirty <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i] <= '0;
                r_age[i] <= 2'(i);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_age[i] <= w_age_next[i];
            end
            if ((r_state == StLookup) && w_hit && r_write) begin
                r_dirty[w_hit_way] <= 1'b1;
            end
            if ((r_state == StFill) && w_fill_last) begin
                r_tag[r_victim]   <= r_addr;
                r_valid[r_victim] <= 1'b1;
                r_dirty[r_victim] <= r_write;
            end
        end
    end

    // Remember the victim chosen in LOOKUP for the WB and FILL states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_victim <= 2'd0;
        end else if (r_state == StLookup) begin
            r_victim <= w_victim;
        end
    end

    // Count FILL cycles so the install lands when memory data is valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fill_cnt <= 2'd0;
        end else if ((r_state == StFill) && !w_fill_last) begin
            r_fill_cnt <= r_fill_cnt + 2'd1;
        end else begin
            r_fill_cnt <= 2'd0;
        end
    end

    // Registered response payload; cleared once the RESP strobe has been shown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                StLookup: begin
                    r_hit <= w_hit;
                    if (w_hit) begin
                        r_rdata <= r_write ? '0 : da_rdata;
                    end
                end
                StFill: begin
                    if (w_fill_last) begin
                        r_rdata <= r_write ? '0 : mem_rdata;
                    end
                end
                StResp: begin
                    r_rdata <= '0;
                    r_hit   <= 1'b0;
                end
                default: begin
                    r_rdata <= r_rdata;
                end
            endcase
        end
    end

    // Saturating hit/miss statistics, counted once per request in LOOKUP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= 8'd0;
            r_miss_cnt <= 8'd0;
        end else if (r_state == StLookup) begin
            if (w_hit) begin
                if (r_hit_cnt != 8'hFF) begin
                    r_hit_cnt <= r_hit_cnt + 8'd1;
                end
            end else if (r_miss_cnt != 8'hFF) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
Sequencing controller for the 4-block fully associative write-back cache. It owns the tag/valid/dirty/LRU directory, accepts one CPU request at a time, and resolves hits locally. It drives the external cache data array and the ramlpm-style synchronous memory to perform dirty write-back and refill on a miss. It sits between the switch/KEY request logic and the cache data array / memory pair, and exports hit/miss statistics for the LEDs.

Parameters:
ADDR_W, 5, address width; the full address is the tag in a fully associative cache.
DATA_W, 5, block width (one word per block).
MEM_LAT, 1, memory read latency in cycles (legal 1..3): rdata is valid MEM_LAT cycles after the address is presented.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data.
req_ready  out  1  controller can accept a request (IDLE only).
resp_valid  out  1  one-cycle response strobe.
resp_rdata  out  DATA_W  read data; 0 on a write response.
resp_hit  out  1  the request hit; valid with resp_valid.
da_way  out  2  data array way select.
da_we  out  1  data array write enable.
da_wdata  out  DATA_W  data array write data.
da_rdata  in  DATA_W  data array combinational read of da_way.
mem_addr  out  ADDR_W  memory address.
mem_we  out  1  memory write enable, one cycle per write-back.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data.
hit_count  out  8  saturating hit counter.
miss_count  out  8  saturating miss counter.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All valid and dirty bits = 0; tags = 0.
  - LRU ages: way0 = 0, way1 = 1, way2 = 2, way3 = 3.
  - All outputs 0 except req_ready = 1; counters = 0.
  - Reset mid-operation aborts the operation: mem_we and da_we drop immediately, and no partial fill is installed.
- States: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, addr and wdata, then go to LOOKUP.
  - req_ready = 0 in every other state. Requests held during busy states are not accepted until IDLE.
- LOOKUP (1 cycle):
  - Compare the latched addr against all valid tags; at most one match.
  - Hit read: da_way = matched way; resp_rdata is registered from da_rdata.
  - Hit write: da_we = 1, da_wdata = wdata, dirty[way] = 1.
  - On a hit, update LRU, increment hit_count, then go to RESP.
  - Miss: victim = lowest-index invalid way, else the way with age 3. Increment miss_count.
  - Miss with a valid, dirty victim goes to WB; otherwise it goes to FILL.
- WB (1 cycle): da_way = victim, mem_we = 1, mem_addr = tag[victim], mem_wdata = da_rdata. Then go to FILL.
- FILL (MEM_LAT+1 cycles):
  - mem_addr = latched addr for all FILL cycles; mem_we = 0.
  - On the last FILL cycle, da_way = victim and da_we = 1. Install tag = addr and valid = 1.
  - Read fill: da_wdata = mem_rdata, dirty = 0, resp_rdata = mem_rdata.
  - Write fill (write-allocate): da_wdata = wdata, dirty = 1.
  - Update LRU, then go to RESP.
- RESP (1 cycle): resp_valid = 1 and resp_hit is held. Then go to IDLE. Outputs are registered and return to 0 after RESP.
- Latency from the accept edge (cycle 0): hit -> resp_valid in cycle 2; clean miss -> cycle 3+MEM_LAT; dirty miss -> cycle 4+MEM_LAT.
- LRU update on an access to way w with old age a:
  - age[w] = 0.
  - Every way with age < a increments by 1.
  - Ages remain a permutation of 0..3 at all times.
- Counters saturate at 255 and do not wrap.
- Tag 0 is a legal address; validity is decided only by the valid bit.

Test Plan:
- Reset, mem[5] = 7, read addr 5 -> FILL; resp_valid in cycle 4 (MEM_LAT = 1), resp_rdata = 7, resp_hit = 0, miss_count = 1, way0 valid.
- Read addr 5 again -> resp_valid in cycle 2, resp_rdata = 7, resp_hit = 1, hit_count = 1, no mem activity.
- Write addr 5 data 9 -> hit, da_we with da_wdata = 9 to way0, dirty. Then read addrs 1, 2, 3 (ways 1-3 filled), then read addr 4 -> WB cycle with mem_we = 1, mem_addr = 5, mem_wdata = 9; then refill of way0; resp in cycle 5.
- req_valid held high through a miss -> req_ready = 0 from LOOKUP to RESP; the second request is accepted only on the first IDLE cycle after RESP.
- Assert reset during FILL -> outputs clear immediately, mem_we = 0, all valid = 0; the next read of the same addr misses.
- Issue 300 hits -> hit_count = 255 and stays there.
